rom_wb_arbiter: RTL and testbench
=================================

Name: rom_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares a single registered-ack memory (boot/program ROM) between the instruction-fetch port (M0) and the data-load port (M1) of the RISC-V core.
- Issues one single-cycle strobe per transaction to the slave, waits for the slave acknowledge, and returns the read data to the granted master.
- Round-robin grant on contention; a bounded-wait timeout returns an error if the slave never acknowledges.

Parameters:
- ADDRESS_WIDTH, 8, address bus width (masters and slave).
- DATA_WIDTH, 8, data bus width.
- TIMEOUT, 15, maximum WAIT cycles before an error (must be ≥ 2). Counter width is $clog2(TIMEOUT+1).

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_NI  in  1  asynchronous active-low reset.
- M0_STB_I  in  1  master 0 request; held until M0_ACK_O or M0_ERR_O.
- M0_WE_I  in  1  master 0 write enable.
- M0_ADR_I  in  ADDRESS_WIDTH  master 0 address.
- M0_DAT_I  in  DATA_WIDTH  master 0 write data.
- M0_DAT_O  out  DATA_WIDTH  master 0 read data.
- M0_ACK_O  out  1  master 0 completion pulse.
- M0_ERR_O  out  1  master 0 timeout pulse.
- M1_STB_I, M1_WE_I, M1_ADR_I, M1_DAT_I, M1_DAT_O, M1_ACK_O, M1_ERR_O: same as M0, for master 1.
- S_STB_O  out  1  slave strobe.
- S_WE_O  out  1  slave write enable.
- S_ADR_O  out  ADDRESS_WIDTH  slave address.
- S_DAT_O  out  DATA_WIDTH  slave write data.
- S_DAT_I  in  DATA_WIDTH  slave read data.
- S_ACK_I  in  1  slave acknowledge.
- GNT_O  out  1  index of the current or last granted master.
- BUSY_O  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (RST_NI low, asynchronous):
  - state = IDLE.
  - All STB, ACK, ERR and WE outputs = 0.
  - All DAT and ADR outputs = 0.
  - GNT_O = 1, so M0 wins the first contention.
  - Wait counter = 0.
- States: IDLE → REQ → WAIT → DONE → IDLE.
- IDLE:
  - If exactly one of M0_STB_I/M1_STB_I is high, grant that master.
  - If both are high, grant the master that is not GNT_O.
  - On grant: latch that master's ADR/WE/DAT into S_ADR_O/S_WE_O/S_DAT_O, set S_STB_O = 1, set GNT_O, and go to REQ.
  - With no request, stay in IDLE.
- REQ (exactly one cycle): S_STB_O = 0 at the next edge, clear the wait counter, go to WAIT. S_STB_O is therefore high for exactly one cycle per transaction.
- WAIT, S_ACK_I high:
  - Granted master's DAT_O ← S_DAT_I and ACK_O = 1 for one cycle.
  - Go to DONE.
- WAIT, S_ACK_I low:
  - Increment the counter.
  - If the counter equals TIMEOUT−1, the granted ERR_O = 1 for one cycle, DAT_O is unchanged, and the state goes to DONE.
  - If S_ACK_I is high in the cycle the timeout would fire, ACK wins.
- DONE (one cycle): clear ACK_O/ERR_O and go to IDLE. Requests are not sampled here, so the master has a cycle to drop or replace STB.
- Latency with a registered-ack slave: request seen in cycle 0 → S_STB_O high in cycle 1 → S_ACK_I in cycle 2 → M_ACK_O high in cycle 3. Peak throughput is one transaction per 4 cycles.
- The non-granted master's outputs are held, with ACK_O/ERR_O = 0.
- S_ACK_I outside WAIT (late or stray) is ignored.
- Master STB dropped mid-transaction: the transaction still completes and the ACK/ERR pulse is still issued.
- Writes are forwarded unchanged; the read data returned for a write is whatever S_DAT_I presents at ack.
- Reset mid-transaction aborts immediately, and no ACK or ERR is issued for the aborted transaction.

Test Plan:
- Reset release, M0_STB_I = 1, M0_ADR_I = 0x10, slave returns 0xA5 one cycle after S_STB_O → S_STB_O high in cycle 1 only with S_ADR_O = 0x10; M0_ACK_O high in cycle 3 with M0_DAT_O = 0xA5; M1 outputs stay 0.
- M0 and M1 both request continuously (ADR 0x01 and 0x02) → grants alternate M0, M1, M0, M1 (GNT_O 0, 1, 0, 1); S_ADR_O alternates 0x01/0x02; one ACK per 4 cycles.
- Slave never acks, TIMEOUT = 15, M1 request → M1_ERR_O pulses exactly once 15 WAIT cycles after REQ; M1_ACK_O stays 0; BUSY_O falls one cycle later.
- Slave acks in the same cycle the timeout would fire → ACK returned, no ERR.
- Stray S_ACK_I pulse while IDLE and again during DONE → no M0_ACK_O/M1_ACK_O and no state change.
- RST_NI asserted during WAIT → outputs return to reset values asynchronously; after release, a fresh M1 request completes normally with GNT_O = 1.

Source files
------------

// File: rtl/rom_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter sharing a registered-ack ROM between
// instruction fetch (M0) and data load (M1), with round-robin grant and timeout.
module rom_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 15
) (
  input  logic                     CLK_I,
  input  logic                     RST_NI,
  input  logic                     M0_STB_I,
  input  logic                     M0_WE_I,
  input  logic [ADDRESS_WIDTH-1:0] M0_ADR_I,
  input  logic [DATA_WIDTH-1:0]    M0_DAT_I,
  output logic [DATA_WIDTH-1:0]    M0_DAT_O,
  output logic                     M0_ACK_O,
  output logic                     M0_ERR_O,
  input  logic                     M1_STB_I,
  input  logic                     M1_WE_I,
  input  logic [ADDRESS_WIDTH-1:0] M1_ADR_I,
  input  logic [DATA_WIDTH-1:0]    M1_DAT_I,
  output logic [DATA_WIDTH-1:0]    M1_DAT_O,
  output logic                     M1_ACK_O,
  output logic                     M1_ERR_O,
  output logic                     S_STB_O,
  output logic                     S_WE_O,
  output logic [ADDRESS_WIDTH-1:0] S_ADR_O,
  output logic [DATA_WIDTH-1:0]    S_DAT_O,
  input  logic [DATA_WIDTH-1:0]    S_DAT_I,
  input  logic                     S_ACK_I,
  output logic                     GNT_O,
  output logic                     BUSY_O
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   r_state, w_state_next;
  logic [CNT_W-1:0]         r_cnt, w_cnt_next;
  logic                     r_s_stb, w_s_stb_next;
  logic                     r_s_we, w_s_we_next;
  logic [ADDRESS_WIDTH-1:0] r_s_adr, w_s_adr_next;
  logic [DATA_WIDTH-1:0]    r_s_dat, w_s_dat_next;
  logic                     r_gnt, w_gnt_next;
  logic                     r_busy, w_busy_next;
  logic [DATA_WIDTH-1:0]    r_m0_dat, w_m0_dat_next;
  logic                     r_m0_ack, w_m0_ack_next;
  logic                     r_m0_err, w_m0_err_next;
  logic [DATA_WIDTH-1:0]    r_m1_dat, w_m1_dat_next;
  logic                     r_m1_ack, w_m1_ack_next;
  logic                     r_m1_err, w_m1_err_next;
  logic                     w_sel;

  // NOTE: every variable gets its hold/default value before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_s_stb_next  = r_s_stb;
    w_s_we_next   = r_s_we;
    w_s_adr_next  = r_s_adr;
    w_s_dat_next  = r_s_dat;
    w_gnt_next    = r_gnt;
    w_m0_dat_next = r_m0_dat;
    w_m1_dat_next = r_m1_dat;
    w_m0_ack_next = 1'b0;
    w_m0_err_next = 1'b0;
    w_m1_ack_next = 1'b0;
    w_m1_err_next = 1'b0;
    // On contention the master that did not win last time gets the bus.
    w_sel         = (M0_STB_I && M1_STB_I) ? ~r_gnt : M1_STB_I;

    case (r_state)
      IDLE: begin
        if (M0_STB_I || M1_STB_I) begin
          w_gnt_next   = w_sel;
          w_s_stb_next = 1'b1;
          w_s_we_next  = w_sel ? M1_WE_I  : M0_WE_I;
          w_s_adr_next = w_sel ? M1_ADR_I : M0_ADR_I;
          w_s_dat_next = w_sel ? M1_DAT_I : M0_DAT_I;
          w_state_next = REQ;
        end
      end
      REQ: begin
        w_s_stb_next = 1'b0;
        w_cnt_next   = '0;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (S_ACK_I) begin
          if (r_gnt) begin
            w_m1_dat_next = S_DAT_I;
            w_m1_ack_next = 1'b1;
          end else begin
            w_m0_dat_next = S_DAT_I;
            w_m0_ack_next = 1'b1;
          end
          w_state_next = DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_m1_err_next = r_gnt;
          w_m0_err_next = ~r_gnt;
          w_state_next  = DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_s_stb  <= 1'b0;
      r_s_we   <= 1'b0;
      r_s_adr  <= '0;
      r_s_dat  <= '0;
      r_gnt    <= 1'b1;
      r_busy   <= 1'b0;
      r_m0_dat <= '0;
      r_m0_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_dat <= '0;
      r_m1_ack <= 1'b0;
      r_m1_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_s_stb  <= w_s_stb_next;
      r_s_we   <= w_s_we_next;
      r_s_adr  <= w_s_adr_next;
      r_s_dat  <= w_s_dat_next;
      r_gnt    <= w_gnt_next;
      r_busy   <= w_busy_next;
      r_m0_dat <= w_m0_dat_next;
      r_m0_ack <= w_m0_ack_next;
      r_m0_err <= w_m0_err_next;
      r_m1_dat <= w_m1_dat_next;
      r_m1_ack <= w_m1_ack_next;
      r_m1_err <= w_m1_err_next;
    end
  end

  assign S_STB_O  = r_s_stb;
  assign S_WE_O   = r_s_we;
  assign S_ADR_O  = r_s_adr;
  assign S_DAT_O  = r_s_dat;
  assign GNT_O    = r_gnt;
  assign BUSY_O   = r_busy;
  assign M0_DAT_O = r_m0_dat;
  assign M0_ACK_O = r_m0_ack;
  assign M0_ERR_O = r_m0_err;
  assign M1_DAT_O = r_m1_dat;
  assign M1_ACK_O = r_m1_ack;
  assign M1_ERR_O = r_m1_err;

endmodule

// File: tb/tb_rom_wb_arbiter.sv
// Directed self-checking bench for rom_wb_arbiter: single read, round-robin,
// timeout, ack-at-timeout, stray acks and reset during WAIT.
module tb_rom_wb_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_stb, m0_we, m1_stb, m1_we;
  logic [7:0] m0_adr, m0_dat_i, m1_adr, m1_dat_i;
  logic [7:0] m0_dat_o, m1_dat_o;
  logic       m0_ack, m0_err, m1_ack, m1_err;
  logic       s_stb, s_we, s_ack;
  logic [7:0] s_adr, s_dat_o, s_dat_i;
  logic       gnt, busy;

  int total = 0;
  int bad   = 0;

  rom_wb_arbiter #(
    .ADDRESS_WIDTH(8),
    .DATA_WIDTH   (8),
    .TIMEOUT      (15)
  ) dut (
    .CLK_I   (clk),
    .RST_NI  (rst_n),
    .M0_STB_I(m0_stb),
    .M0_WE_I (m0_we),
    .M0_ADR_I(m0_adr),
    .M0_DAT_I(m0_dat_i),
    .M0_DAT_O(m0_dat_o),
    .M0_ACK_O(m0_ack),
    .M0_ERR_O(m0_err),
    .M1_STB_I(m1_stb),
    .M1_WE_I (m1_we),
    .M1_ADR_I(m1_adr),
    .M1_DAT_I(m1_dat_i),
    .M1_DAT_O(m1_dat_o),
    .M1_ACK_O(m1_ack),
    .M1_ERR_O(m1_err),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADR_O (s_adr),
    .S_DAT_O (s_dat_o),
    .S_DAT_I (s_dat_i),
    .S_ACK_I (s_ack),
    .GNT_O   (gnt),
    .BUSY_O  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here apply to the
  // new cycle and outputs read here are the values registered at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with the request(s) already driven; ends in the
  // IDLE cycle four edges later. The slave acks one cycle after its strobe.
  task automatic txn(input logic g, input logic [7:0] adr, input logic [7:0] data,
                     input logic last);
    tick();
    check("req_stb", s_stb, 1);
    check("req_adr", s_adr, adr);
    check("req_gnt", gnt, g);
    tick();
    check("wait_stb_low", s_stb, 0);
    s_ack   = 1'b1;
    s_dat_i = data;
    tick();
    s_ack = 1'b0;
    check("ack_granted", g ? m1_ack : m0_ack, 1);
    check("ack_other", g ? m0_ack : m1_ack, 0);
    check("dat_granted", g ? m1_dat_o : m0_dat_o, data);
    if (last) begin
      m0_stb = 1'b0;
      m1_stb = 1'b0;
    end
    tick();
    check("ack_cleared", {m0_ack, m1_ack}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 8'h00; m0_dat_i = 8'h00;
    m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 8'h00; m1_dat_i = 8'h00;
    s_ack = 1'b0; s_dat_i = 8'h00;

    // Reset state
    repeat (2) tick();
    check("rst_stb", s_stb, 0);
    check("rst_gnt", gnt, 1);
    check("rst_busy", busy, 0);
    check("rst_adr", s_adr, 0);
    check("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    rst_n = 1'b1;

    // Single M0 read: strobe in cycle 1, ack in cycle 3 with 0xA5
    m0_stb = 1'b1;
    m0_adr = 8'h10;
    txn(1'b0, 8'h10, 8'hA5, 1'b1);
    check("t1_busy_idle", busy, 0);
    check("t1_m1_dat", m1_dat_o, 0);
    check("t1_m1_flags", {m1_ack, m1_err}, 0);

    // Fresh reset so the first contention goes to M0, then alternate
    rst_n = 1'b0;
    #2;
    check("rr_rst_gnt", gnt, 1);
    rst_n = 1'b1;
    m0_stb = 1'b1; m0_adr = 8'h01;
    m1_stb = 1'b1; m1_adr = 8'h02;
    txn(1'b0, 8'h01, 8'h11, 1'b0);
    txn(1'b1, 8'h02, 8'h22, 1'b0);
    txn(1'b0, 8'h01, 8'h33, 1'b0);
    txn(1'b1, 8'h02, 8'h44, 1'b1);
    check("rr_busy_end", busy, 0);

    // M1 request with a silent slave: ERR after 15 WAIT cycles
    m1_stb = 1'b1;
    m1_adr = 8'h33;
    tick();
    check("to_req_stb", s_stb, 1);
    check("to_req_gnt", gnt, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_no_err_yet", {m1_err, m1_ack}, 0);
    end
    tick();
    check("to_err", m1_err, 1);
    check("to_no_ack", m1_ack, 0);
    check("to_dat_held", m1_dat_o, 8'h44);
    check("to_m0_quiet", {m0_ack, m0_err}, 0);
    check("to_busy_done", busy, 1);
    m1_stb = 1'b0;
    tick();
    check("to_err_pulse", m1_err, 0);
    check("to_busy_fall", busy, 0);

    // Ack arriving in the very cycle the timeout would fire wins
    m0_stb = 1'b1;
    m0_adr = 8'h40;
    tick();
    check("ta_req_gnt", gnt, 0);
    repeat (14) tick();
    check("ta_no_err_early", m0_err, 0);
    tick();
    s_ack   = 1'b1;
    s_dat_i = 8'h5C;
    tick();
    s_ack = 1'b0;
    check("ta_ack", m0_ack, 1);
    check("ta_no_err", m0_err, 0);
    check("ta_dat", m0_dat_o, 8'h5C);
    m0_stb = 1'b0;
    tick();
    check("ta_idle_err", {m0_err, m0_ack}, 0);
    check("ta_idle_busy", busy, 0);

    // Stray ack while IDLE
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    check("stray_idle_acks", {m0_ack, m1_ack}, 0);
    check("stray_idle_busy", busy, 0);
    check("stray_idle_stb", s_stb, 0);

    // M1 write forwarded, then a stray ack during DONE
    m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 8'h55; m1_dat_i = 8'h77;
    tick();
    check("wr_we", s_we, 1);
    check("wr_dat", s_dat_o, 8'h77);
    check("wr_adr", s_adr, 8'h55);
    check("wr_gnt", gnt, 1);
    tick();
    s_ack   = 1'b1;
    s_dat_i = 8'h99;
    tick();
    check("wr_ack", m1_ack, 1);
    check("wr_rdat", m1_dat_o, 8'h99);
    m1_stb = 1'b0;
    m1_we  = 1'b0;
    tick();
    s_ack = 1'b0;
    check("stray_done_acks", {m0_ack, m1_ack}, 0);
    check("stray_done_busy", busy, 0);
    check("stray_done_stb", s_stb, 0);
    tick();
    check("stray_after_acks", {m0_ack, m1_ack}, 0);
    check("stray_after_busy", busy, 0);

    // Reset asserted during WAIT aborts without ACK/ERR
    m0_stb = 1'b1;
    m0_adr = 8'h66;
    tick();
    tick();
    check("rw_in_wait", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rw_busy", busy, 0);
    check("rw_gnt", gnt, 1);
    check("rw_adr", s_adr, 0);
    check("rw_dat", {m0_dat_o, m1_dat_o}, 0);
    check("rw_flags", {s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err}, 0);
    m0_stb = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check("rw_no_pulse", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    check("rw_idle", busy, 0);
    m1_stb = 1'b1;
    m1_adr = 8'h21;
    txn(1'b1, 8'h21, 8'hC3, 1'b1);
    check("rw_m0_dat", m0_dat_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
